// File: rtl/hilo_pkg.sv
// Shared definitions for the HI/LO multiply/divide-unit controller:
// ALU control codes, FSM state encoding, datapath widths and op decode helpers.
package hilo_pkg;

    localparam logic [5:0] OP_MULT  = 6'd4;
    localparam logic [5:0] OP_MULTU = 6'd24;
    localparam logic [5:0] OP_MADD  = 6'd16;
    localparam logic [5:0] OP_MSUB  = 6'd17;
    localparam logic [5:0] OP_MUL   = 6'd8;
    localparam logic [5:0] OP_MTHI  = 6'd30;
    localparam logic [5:0] OP_MTLO  = 6'd29;
    localparam logic [5:0] OP_MFHI  = 6'd31;
    localparam logic [5:0] OP_MFLO  = 6'd23;

    localparam int OPND_W = 32;
    localparam int PROD_W = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    // Codes that start an iterative multiply sequence
    function automatic logic mul_class(input logic [5:0] op);
        return op inside {OP_MULT, OP_MULTU, OP_MADD, OP_MSUB, OP_MUL};
    endfunction

    // Codes whose operands are treated as two's-complement
    function automatic logic signed_op(input logic [5:0] op);
        return op inside {OP_MULT, OP_MADD, OP_MSUB, OP_MUL};
    endfunction

    // Every code this unit reacts to; anything else is ignored
    function automatic logic recognised(input logic [5:0] op);
        return mul_class(op) || (op inside {OP_MTHI, OP_MTLO, OP_MFHI, OP_MFLO});
    endfunction

endpackage

// File: rtl/hilo_muldiv_ctrl_if.sv
// Execute-stage request/response bundle between the pipeline and the HI/LO unit.
interface hilo_muldiv_ctrl_if;

    logic        Start;
    logic [5:0]  ALUCtrl;
    logic [31:0] A;
    logic [31:0] B;
    logic        Busy;
    logic        Stall;
    logic        Done;
    logic [31:0] Result;
    logic [31:0] HI;
    logic [31:0] LO;

    modport master (
        output Start, ALUCtrl, A, B,
        input  Busy, Stall, Done, Result, HI, LO
    );

    modport slave (
        input  Start, ALUCtrl, A, B,
        output Busy, Stall, Done, Result, HI, LO
    );

endinterface

// File: rtl/mul_iter_core.sv
// Unsigned shift-add multiplier retiring BITS_PER_CYCLE multiplier bits per step.
// The multiplier sits in the low half of the product register and is shifted
// out as partial sums are shifted in from the top.
module mul_iter_core
    import hilo_pkg::*;
#(
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              step,
    input  logic [OPND_W-1:0] mcand,
    input  logic [OPND_W-1:0] mplier,
    output logic [PROD_W-1:0] product
);

    // The upper accumulator stays below mcand, so mcand*(digit+1) fits here
    localparam int SUM_W = OPND_W + BITS_PER_CYCLE;

    logic [OPND_W-1:0]         mcand_q;
    logic [PROD_W-1:0]         prod_q;
    logic [BITS_PER_CYCLE-1:0] digit;
    logic [SUM_W-1:0]          partial;

    assign digit   = prod_q[BITS_PER_CYCLE-1:0];
    assign partial = SUM_W'(prod_q[PROD_W-1:OPND_W]) + SUM_W'(mcand_q) * SUM_W'(digit);
    assign product = prod_q;

    // Load operands, then add-and-shift one multiplier digit per step
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_q <= '0;
            prod_q  <= '0;
        end else if (load) begin
            mcand_q <= mcand;
            prod_q  <= {{OPND_W{1'b0}}, mplier};
        end else if (step) begin
            prod_q  <= {partial, prod_q[OPND_W-1:BITS_PER_CYCLE]};
        end
    end

endmodule

// File: rtl/hilo_muldiv_ctrl.sv
// HI/LO controller: sequences iterative multiplies, owns the HI/LO registers,
// serves MTHI/MTLO/MFHI/MFLO and stalls the pipeline while a multiply runs.
module hilo_muldiv_ctrl
    import hilo_pkg::*;
#(
    parameter int BITS_PER_CYCLE = 1
) (
    input logic               Clk,
    input logic               Reset_n,
    hilo_muldiv_ctrl_if.slave bus
);

    localparam logic [5:0] RUN_CYCLES = 6'(OPND_W / BITS_PER_CYCLE);

    state_t            state;
    logic              busy_q;
    logic              done_q;
    logic [5:0]        op_q;
    logic              sign_q;
    logic [5:0]        count_q;
    logic [31:0]       hi_q;
    logic [31:0]       lo_q;
    logic [31:0]       result_q;
    logic [31:0]       result_out;
    logic              accept;
    logic              step;
    logic              is_signed;
    logic [31:0]       a_mag;
    logic [31:0]       b_mag;
    logic [PROD_W-1:0] product;
    logic [PROD_W-1:0] fixed;
    logic [PROD_W-1:0] hilo_sum;
    logic [PROD_W-1:0] hilo_diff;

    assign is_signed = signed_op(bus.ALUCtrl);
    assign a_mag     = (is_signed && bus.A[31]) ? (~bus.A + 32'd1) : bus.A;
    assign b_mag     = (is_signed && bus.B[31]) ? (~bus.B + 32'd1) : bus.B;
    assign accept    = bus.Start && (state == IDLE) && mul_class(bus.ALUCtrl);
    assign step      = (state == RUN);

    // Sign is restored only once the magnitude product is complete
    assign fixed     = sign_q ? (~product + 64'd1) : product;
    assign hilo_sum  = {hi_q, lo_q} + fixed;
    assign hilo_diff = {hi_q, lo_q} - fixed;

    mul_iter_core #(
        .BITS_PER_CYCLE(BITS_PER_CYCLE)
    ) u_core (
        .clk    (Clk),
        .rst_n  (Reset_n),
        .load   (accept),
        .step   (step),
        .mcand  (a_mag),
        .mplier (b_mag),
        .product(product)
    );

    // Sequencer plus HI/LO/Result state; a reset abandons any sequence in flight
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state    <= IDLE;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            op_q     <= '0;
            sign_q   <= 1'b0;
            count_q  <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            result_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        state   <= RUN;
                        busy_q  <= 1'b1;
                        op_q    <= bus.ALUCtrl;
                        sign_q  <= is_signed && (bus.A[31] ^ bus.B[31]);
                        count_q <= RUN_CYCLES;
                    end else if (bus.Start) begin
                        case (bus.ALUCtrl)
                            OP_MTHI: hi_q     <= bus.A;
                            OP_MTLO: lo_q     <= bus.A;
                            OP_MFHI: result_q <= hi_q;
                            OP_MFLO: result_q <= lo_q;
                            default: ;
                        endcase
                    end
                end
                RUN: begin
                    count_q <= count_q - 6'd1;
                    if (count_q == 6'd1) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                    case (op_q)
                        OP_MULT, OP_MULTU: {hi_q, lo_q} <= fixed;
                        OP_MADD:           {hi_q, lo_q} <= hilo_sum;
                        OP_MSUB:           {hi_q, lo_q} <= hilo_diff;
                        OP_MUL:            result_q     <= fixed[31:0];
                        default: ;
                    endcase
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    // MFHI/MFLO read straight through while idle, otherwise the held result
    always_comb begin
        result_out = result_q;
        if ((state == IDLE) && bus.Start) begin
            if (bus.ALUCtrl == OP_MFHI) begin
                result_out = hi_q;
            end else if (bus.ALUCtrl == OP_MFLO) begin
                result_out = lo_q;
            end
        end
    end

    assign bus.Busy   = busy_q;
    assign bus.Stall  = busy_q && bus.Start && recognised(bus.ALUCtrl);
    assign bus.Done   = done_q;
    assign bus.Result = result_out;
    assign bus.HI     = hi_q;
    assign bus.LO     = lo_q;

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// Self-checking bench for hilo_muldiv_ctrl: directed corner cases followed by
// random operation streams compared against a plain-arithmetic HI/LO model.
module tb_hilo_muldiv_ctrl;

    localparam int BPC        = 1;
    localparam int DONE_EDGES = 32 / BPC + 1;

    localparam logic [5:0] C_MULT  = 6'd4;
    localparam logic [5:0] C_MULTU = 6'd24;
    localparam logic [5:0] C_MADD  = 6'd16;
    localparam logic [5:0] C_MSUB  = 6'd17;
    localparam logic [5:0] C_MUL   = 6'd8;
    localparam logic [5:0] C_MTHI  = 6'd30;
    localparam logic [5:0] C_MTLO  = 6'd29;
    localparam logic [5:0] C_MFHI  = 6'd31;
    localparam logic [5:0] C_MFLO  = 6'd23;

    logic        Clk = 1'b0;
    logic        Reset_n;
    int          errors = 0;
    int          checks = 0;
    logic [31:0] mHi;
    logic [31:0] mLo;
    logic [31:0] mRes;

    hilo_muldiv_ctrl_if bus();

    hilo_muldiv_ctrl #(
        .BITS_PER_CYCLE(BPC)
    ) dut (
        .Clk    (Clk),
        .Reset_n(Reset_n),
        .bus    (bus)
    );

    always #5 Clk = ~Clk;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic isMulClass(input logic [5:0] op);
        return (op == C_MULT) || (op == C_MULTU) || (op == C_MADD) ||
               (op == C_MSUB) || (op == C_MUL);
    endfunction

    function automatic logic isRecognised(input logic [5:0] op);
        return isMulClass(op) || (op == C_MTHI) || (op == C_MTLO) ||
               (op == C_MFHI) || (op == C_MFLO);
    endfunction

    // Full 64-bit product by ordinary integer arithmetic
    function automatic logic [63:0] refProduct(input logic [5:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
        longint          sa;
        longint          sb;
        longint unsigned ua;
        longint unsigned ub;
        if (op == C_MULTU) begin
            ua = a;
            ub = b;
            return ua * ub;
        end
        sa = $signed(a);
        sb = $signed(b);
        return sa * sb;
    endfunction

    // Architectural effect of one accepted operation
    task automatic modelUpdate(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        p = refProduct(op, a, b);
        case (op)
            C_MULT, C_MULTU: {mHi, mLo} = p;
            C_MADD:          {mHi, mLo} = {mHi, mLo} + p;
            C_MSUB:          {mHi, mLo} = {mHi, mLo} - p;
            C_MUL:           mRes = p[31:0];
            C_MTHI:          mHi = a;
            C_MTLO:          mLo = a;
            C_MFHI:          mRes = mHi;
            C_MFLO:          mRes = mLo;
            default: ;
        endcase
    endtask

    function automatic logic [31:0] randOperand();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'h0000_0001;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    function automatic logic [5:0] randInvalid();
        logic [5:0] op;
        op = 6'($urandom_range(0, 63));
        while (isRecognised(op)) op = 6'($urandom_range(0, 63));
        return op;
    endfunction

    // Issue one op at posedge+1, follow it to completion, compare against the model
    task automatic applyStimulus(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
        int n;
        bus.Start   = 1'b1;
        bus.ALUCtrl = op;
        bus.A       = a;
        bus.B       = b;
        #1;
        checkOutput("stall_when_idle", bus.Stall, 1'b0);
        if (op == C_MFHI) checkOutput("mfhi_same_cycle", bus.Result, mHi);
        if (op == C_MFLO) checkOutput("mflo_same_cycle", bus.Result, mLo);
        @(posedge Clk);
        #1;
        bus.Start = 1'b0;
        modelUpdate(op, a, b);
        if (isMulClass(op)) begin
            checkOutput("busy_after_accept", bus.Busy, 1'b1);
            n = 0;
            while (bus.Done !== 1'b1 && n < 4 * DONE_EDGES) begin
                @(posedge Clk);
                #1;
                n++;
            end
            checkOutput("done_latency", n, DONE_EDGES);
            checkOutput("busy_in_done", bus.Busy, 1'b0);
        end else begin
            checkOutput("busy_after_idle_op", bus.Busy, 1'b0);
            checkOutput("no_done_idle_op", bus.Done, 1'b0);
        end
        checkOutput("hi", bus.HI, mHi);
        checkOutput("lo", bus.LO, mLo);
        checkOutput("result", bus.Result, mRes);
    endtask

    // MFHI requested while a MULT runs: stalled until Done, then fresh HI
    task automatic mfhiDuringRun(input logic [31:0] a, input logic [31:0] b);
        int   n;
        logic stallDropped;
        bus.Start   = 1'b1;
        bus.ALUCtrl = C_MULT;
        bus.A       = a;
        bus.B       = b;
        @(posedge Clk);
        #1;
        modelUpdate(C_MULT, a, b);
        bus.ALUCtrl = randInvalid();
        #1;
        checkOutput("stall_unrecognised_busy", bus.Stall, 1'b0);
        @(posedge Clk);
        #1;
        bus.ALUCtrl  = C_MFHI;
        stallDropped = 1'b0;
        n            = 0;
        #1;
        while (bus.Done !== 1'b1 && n < 4 * DONE_EDGES) begin
            if (bus.Stall !== 1'b1) stallDropped = 1'b1;
            @(posedge Clk);
            #1;
            n++;
        end
        checkOutput("stall_held_while_busy", stallDropped, 1'b0);
        checkOutput("done_seen_after_stall", bus.Done, 1'b1);
        checkOutput("stall_in_done_cycle", bus.Stall, 1'b0);
        checkOutput("mfhi_in_done_cycle", bus.Result, mHi);
        @(posedge Clk);
        #1;
        bus.Start = 1'b0;
        mRes      = mHi;
        checkOutput("mfhi_result_held", bus.Result, mRes);
    endtask

    // Reset pulsed mid-RUN, then a MULT presented on the first edge after release
    task automatic resetMidRun();
        bus.Start   = 1'b1;
        bus.ALUCtrl = C_MULT;
        bus.A       = $urandom;
        bus.B       = $urandom;
        @(posedge Clk);
        #1;
        bus.Start = 1'b0;
        repeat (10) @(posedge Clk);
        #3;
        Reset_n   = 1'b0;
        bus.Start = 1'b1;
        bus.A     = 32'd2;
        bus.B     = 32'd3;
        #1;
        mHi  = '0;
        mLo  = '0;
        mRes = '0;
        checkOutput("rst_busy", bus.Busy, 1'b0);
        checkOutput("rst_stall", bus.Stall, 1'b0);
        checkOutput("rst_done", bus.Done, 1'b0);
        checkOutput("rst_hi", bus.HI, 32'd0);
        checkOutput("rst_lo", bus.LO, 32'd0);
        checkOutput("rst_result", bus.Result, 32'd0);
        @(posedge Clk);
        @(negedge Clk);
        checkOutput("rst_done_held", bus.Done, 1'b0);
        Reset_n = 1'b1;
        applyStimulus(C_MULT, 32'd2, 32'd3);
        checkOutput("post_reset_lo", bus.LO, 32'd6);
        checkOutput("post_reset_hi", bus.HI, 32'd0);
    endtask

    initial begin
        logic [5:0] opTable [9];
        logic [5:0] op;
        int         sel;
        opTable = '{C_MULT, C_MULTU, C_MADD, C_MSUB, C_MUL, C_MTHI, C_MTLO, C_MFHI, C_MFLO};

        bus.Start   = 1'b0;
        bus.ALUCtrl = '0;
        bus.A       = '0;
        bus.B       = '0;
        Reset_n     = 1'b0;
        mHi         = '0;
        mLo         = '0;
        mRes        = '0;

        repeat (2) @(posedge Clk);
        #1;
        checkOutput("reset_busy", bus.Busy, 1'b0);
        checkOutput("reset_stall", bus.Stall, 1'b0);
        checkOutput("reset_done", bus.Done, 1'b0);
        checkOutput("reset_hi", bus.HI, 32'd0);
        checkOutput("reset_lo", bus.LO, 32'd0);
        checkOutput("reset_result", bus.Result, 32'd0);
        @(negedge Clk);
        Reset_n = 1'b1;
        @(posedge Clk);
        #1;

        applyStimulus(C_MULT, 32'hFFFF_FFFD, 32'd5);
        checkOutput("mult_neg3x5_hi", bus.HI, 32'hFFFF_FFFF);
        checkOutput("mult_neg3x5_lo", bus.LO, 32'hFFFF_FFF1);

        applyStimulus(C_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        checkOutput("multu_max_hi", bus.HI, 32'hFFFF_FFFE);
        checkOutput("multu_max_lo", bus.LO, 32'h0000_0001);

        applyStimulus(C_MTHI, 32'd0, 32'd0);
        applyStimulus(C_MTLO, 32'h10, 32'd0);
        applyStimulus(C_MADD, 32'd3, 32'd4);
        checkOutput("madd_lo", bus.LO, 32'h1C);
        checkOutput("madd_hi", bus.HI, 32'd0);
        applyStimulus(C_MSUB, 32'h1C, 32'd1);
        checkOutput("msub_lo", bus.LO, 32'd0);
        checkOutput("msub_hi", bus.HI, 32'd0);

        applyStimulus(C_MTHI, 32'hAA, 32'd0);
        applyStimulus(C_MTLO, 32'hBB, 32'd0);
        applyStimulus(C_MUL, 32'd7, 32'd6);
        checkOutput("mul_result", bus.Result, 32'd42);
        checkOutput("mul_hi_kept", bus.HI, 32'hAA);
        checkOutput("mul_lo_kept", bus.LO, 32'hBB);

        applyStimulus(randInvalid(), $urandom, $urandom);

        mfhiDuringRun(32'hFFFF_FFF0, 32'h0000_1234);

        resetMidRun();

        for (int i = 0; i < 40; i++) begin
            sel = $urandom_range(0, 9);
            op  = (sel == 9) ? randInvalid() : opTable[sel];
            applyStimulus(op, randOperand(), randOperand());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hilo_muldiv_ctrl.md
HILO_MULDIV_CTRL -- requirements
Module: hilo_muldiv_ctrl

Interface
REQ-001 SHALL have parameter BITS_PER_CYCLE, default 1, multiplier bits retired per RUN cycle; legal values 1, 2, 4.
REQ-002 SHALL have port Clk  input  1  single clock; all state changes on the rising edge.
REQ-003 SHALL have port Reset_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port Start  input  1  the execute stage presents an operation.
REQ-005 SHALL have port ALUCtrl  input  6  operation code from ALU control.
REQ-006 SHALL have port A  input  32  rs operand.
REQ-007 SHALL have port B  input  32  rt operand.
REQ-008 SHALL have port Busy  output  1  a multiply sequence is in progress.
REQ-009 SHALL have port Stall  output  1  hold the pipeline; the Start request was not accepted.
REQ-010 SHALL have port Done  output  1  one-cycle pulse when a multiply sequence completes.
REQ-011 SHALL have port Result  output  32  MFHI/MFLO/MUL result.
REQ-012 SHALL have ports HI and LO  output  32 each  architectural HI/LO registers.

Function
REQ-013 SHALL recognise these codes: 4 MULT, 24 MULTU, 16 MADD, 17 MSUB, 8 MUL, 30 MTHI, 29 MTLO, 31 MFHI, 23 MFLO.
- Start with any other code SHALL be ignored: no state change and Stall=0.
REQ-014 SHALL implement the FSM states IDLE, RUN and FIX.
- IDLE->RUN: on an accepted multiply-class Start (4/24/16/17/8).
- RUN->FIX: after 32/BPC cycles.
- FIX->IDLE: after one cycle.
REQ-015 SHALL accept multiply-class Start only in IDLE.
- On acceptance, latch the operand magnitudes, the product sign (signed codes only), the op code and a down-counter.
REQ-016 SHALL hold Busy=1 in RUN and FIX, and Busy=0 in IDLE.
REQ-017 SHALL compute the unsigned 64-bit product in RUN.
- In FIX, negate the product if the sign flag is set.
REQ-018 SHALL apply the FIX result to HI/LO at the edge that ends FIX:
- MULT/MULTU: {HI,LO} = product.
- MADD: {HI,LO} = {HI,LO} + product.
- MSUB: {HI,LO} = {HI,LO} - product.
- All arithmetic modulo 2^64.
REQ-019 For MUL, SHALL set Result = product[31:0] at the edge ending FIX and leave HI/LO unchanged.
REQ-020 SHALL assert Done for exactly the one cycle after FIX, with Busy=0 in that cycle.
- A new Start SHALL be accepted in the Done cycle.
REQ-021 Latency at BPC=1: accept edge E, HI/LO and Result valid after edge E+33, Done high in the cycle following edge E+33.
REQ-022 SHALL write MTHI/MTLO (HI=A / LO=A) at the next edge when IDLE, with no Busy and no Done.
REQ-023 SHALL drive Result=HI for MFHI and Result=LO for MFLO combinationally in the same cycle when IDLE.
REQ-024 When Busy=1, SHALL drive Stall=Start for every recognised code.
- The requester holds Start, ALUCtrl, A and B stable until Stall falls.
- Operands are not re-sampled mid-sequence.
REQ-025 MFHI/MFLO issued in the Done cycle SHALL return the updated HI/LO.
REQ-026 SHALL hold Result when no MUL/MFHI/MFLO is active.

Reset
REQ-027 Reset_n=0 SHALL force the following at any time, including mid-RUN or mid-FIX:
- state = IDLE;
- HI, LO, Result and counter = 0;
- Busy, Stall and Done = 0.
REQ-028 A sequence aborted by reset SHALL have no effect on HI/LO after reset is released.
REQ-029 SHALL accept Start on the first rising edge after Reset_n deasserts.

Structure
REQ-030 SHALL place in the shared package hilo_pkg:
- the ALUCtrl code constants listed in REQ-013;
- the state encoding (IDLE/RUN/FIX);
- the 64-bit product width constant.
REQ-031 SHALL isolate the shift-add datapath in one sub-module, mul_iter_core (load, step, product out), parameterised by BITS_PER_CYCLE.
- The FSM, HI/LO registers and the stall logic stay in hilo_muldiv_ctrl.

Verification
REQ-032 MULT A=0xFFFFFFFD (-3), B=5 -> Done after 34 cycles; HI=0xFFFFFFFF, LO=0xFFFFFFF1.
REQ-033 MULTU A=B=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
REQ-034 MTHI 0, MTLO 0x10, then MADD 3*4 -> LO=0x1C, HI=0; then MSUB 0x1C*1 -> HI=LO=0.
REQ-035 MFHI asserted 2 cycles after a MULT start -> Stall=1 until the Done cycle; then Result=HI from the new product, with no cycle lost after Done.
REQ-036 MUL 7*6 with HI=0xAA, LO=0xBB -> Result=42; HI/LO unchanged.
REQ-037 Reset_n pulsed low at RUN cycle 10 -> Busy=0, HI=LO=0, no Done pulse; the next MULT 2*3 gives LO=6.
